// File: rtl/mul_add_pkg.sv
// mul_add_pkg: default widths, partial-product widths and stage-valid type for the mul_add_pipe54 datapath
package mul_add_pkg;
  localparam int A_W = 54;
  localparam int B_W = 54;
  localparam int C_W = 105;
  localparam int SPLIT = 27;
  localparam int PP_LO_W = A_W + SPLIT;
  localparam int PP_HI_W = A_W + B_W - SPLIT;
  typedef logic [3:1] stage_vld_t;
endpackage

// File: rtl/mul_add_pp_stage.sv
// mul_add_pp_stage: registered regA*regB[SPLIT-1:0] and regA*regB[B_W-1:SPLIT], loaded when en (clock, active-low async reset, en, a, b -> pp_lo, pp_hi)
module mul_add_pp_stage #(
  parameter int A_W = mul_add_pkg::A_W,
  parameter int B_W = mul_add_pkg::B_W,
  parameter int SPLIT = mul_add_pkg::SPLIT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic [A_W-1:0]           a,
  input  logic [B_W-1:0]           b,
  output logic [A_W+SPLIT-1:0]     pp_lo,
  output logic [A_W+B_W-SPLIT-1:0] pp_hi
);
  localparam int LO_W = A_W + SPLIT;
  localparam int HI_W = A_W + B_W - SPLIT;
  logic [LO_W-1:0] pp_lo_d, pp_lo_q;
  logic [HI_W-1:0] pp_hi_d, pp_hi_q;
  always_comb begin
    pp_lo_d = en ? LO_W'(a) * LO_W'(b[SPLIT-1:0]) : pp_lo_q;
    pp_hi_d = en ? HI_W'(a) * HI_W'(b[B_W-1:SPLIT]) : pp_hi_q;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pp_lo_q <= '0;
      pp_hi_q <= '0;
    end else begin
      pp_lo_q <= pp_lo_d;
      pp_hi_q <= pp_hi_d;
    end
  assign pp_lo = pp_lo_q;
  assign pp_hi = pp_hi_q;
endmodule

// File: rtl/mul_add_pipe54.sv
// mul_add_pipe54: 3-cycle (A*B+C) mod 2^C_W responder; in io_val/latch_a/a/latch_b/b_s0, io_c_s2; out io_result_s3, io_val_s3, plus sticky io_proto_err when MUL_ADD_PROTO_CHECK_EN is defined
module mul_add_pipe54 #(
  parameter int A_W = mul_add_pkg::A_W,
  parameter int B_W = mul_add_pkg::B_W,
  parameter int C_W = mul_add_pkg::C_W,
  parameter int SPLIT = mul_add_pkg::SPLIT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           io_val_s0,
  input  logic           io_latch_a_s0,
  input  logic [A_W-1:0] io_a_s0,
  input  logic           io_latch_b_s0,
  input  logic [B_W-1:0] io_b_s0,
  input  logic [C_W-1:0] io_c_s2,
  output logic [C_W-1:0] io_result_s3,
  output logic           io_val_s3
`ifdef MUL_ADD_PROTO_CHECK_EN
  ,
  output logic           io_proto_err
`endif
);
  import mul_add_pkg::*;
  localparam int LO_W = A_W + SPLIT;
  localparam int HI_W = A_W + B_W - SPLIT;
  logic [1:0] rst_sync_q;
  logic rst_n;
  logic [A_W-1:0] a_d, a_q;
  logic [B_W-1:0] b_d, b_q;
  logic [C_W-1:0] res_d, res_q;
  stage_vld_t vld_d, vld_q;
  logic [LO_W-1:0] pp_lo;
  logic [HI_W-1:0] pp_hi;
  always_ff @(posedge clock or negedge reset)
    if (!reset) rst_sync_q <= 2'b00;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];
  always_comb begin
    a_d = (io_val_s0 && io_latch_a_s0) ? io_a_s0 : a_q;
    b_d = (io_val_s0 && io_latch_b_s0) ? io_b_s0 : b_q;
    vld_d = {vld_q[2], vld_q[1], io_val_s0};
    res_d = vld_q[2] ? C_W'(pp_lo) + (C_W'(pp_hi) << SPLIT) + io_c_s2 : res_q;
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      vld_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      vld_q <= vld_d;
    end
  mul_add_pp_stage #(.A_W(A_W), .B_W(B_W), .SPLIT(SPLIT)) u_pp (
    .clock(clock),
    .reset(rst_n),
    .en(vld_q[1]),
    .a(a_q),
    .b(b_q),
    .pp_lo(pp_lo),
    .pp_hi(pp_hi)
  );
  assign io_result_s3 = res_q;
  assign io_val_s3 = vld_q[3];
`ifdef MUL_ADD_PROTO_CHECK_EN
  logic lda_d, lda_q, ldb_d, ldb_q, err_d, err_q;
  always_comb begin
    lda_d = lda_q | (io_val_s0 & io_latch_a_s0);
    ldb_d = ldb_q | (io_val_s0 & io_latch_b_s0);
    err_d = err_q | (~io_val_s0 & (io_latch_a_s0 | io_latch_b_s0))
          | (io_val_s0 & ~((lda_q | io_latch_a_s0) & (ldb_q | io_latch_b_s0)));
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      lda_q <= 1'b0;
      ldb_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      lda_q <= lda_d;
      ldb_q <= ldb_d;
      err_q <= err_d;
    end
  assign io_proto_err = err_q;
`endif
endmodule

// File: tb/tb_mul_add_pipe54.sv
// tb_mul_add_pipe54: random and directed stimulus checked every cycle against a full-product reference model
module tb_mul_add_pipe54;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic io_val_s0 = 1'b0, io_latch_a_s0 = 1'b0, io_latch_b_s0 = 1'b0;
  logic [53:0] io_a_s0 = '0, io_b_s0 = '0;
  logic [104:0] io_c_s2 = '0;
  logic [104:0] io_result_s3;
  logic io_val_s3;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  mul_add_pipe54 dut (
    .clock(clock),
    .reset(reset),
    .io_val_s0(io_val_s0),
    .io_latch_a_s0(io_latch_a_s0),
    .io_a_s0(io_a_s0),
    .io_latch_b_s0(io_latch_b_s0),
    .io_b_s0(io_b_s0),
    .io_c_s2(io_c_s2),
    .io_result_s3(io_result_s3),
    .io_val_s3(io_val_s3)
`ifdef MUL_ADD_PROTO_CHECK_EN
    ,
    .io_proto_err(io_proto_err)
`endif
  );
`ifdef MUL_ADD_PROTO_CHECK_EN
  logic io_proto_err;
  logic m_lda, m_ldb, m_err;
`endif
  task automatic chk(input string name, input logic [104:0] act, input logic [104:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: full 108-bit product formed at issue, carried two cycles, C added at stage 2.
  // Reset release is seen two clocks late because the block synchronises it internally.
  logic [53:0] ma, mb;
  logic [107:0] p1, p2, s;
  logic [104:0] r3;
  logic v1, v2, v3;
  int rs;
  always @(posedge clock or negedge reset) begin
    if (!reset || rs < 2) begin
      if (!reset) rs = 0;
      else rs++;
      ma = '0; mb = '0; p1 = '0; p2 = '0; r3 = '0;
      v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
`ifdef MUL_ADD_PROTO_CHECK_EN
      m_lda = 1'b0; m_ldb = 1'b0; m_err = 1'b0;
`endif
    end else begin
      if (v2) begin
        s = p2 + 108'(io_c_s2);
        r3 = s[104:0];
      end
      v3 = v2;
      p2 = p1;
      v2 = v1;
`ifdef MUL_ADD_PROTO_CHECK_EN
      if (!io_val_s0 && (io_latch_a_s0 || io_latch_b_s0)) m_err = 1'b1;
      if (io_val_s0 && !((m_lda || io_latch_a_s0) && (m_ldb || io_latch_b_s0))) m_err = 1'b1;
      if (io_val_s0 && io_latch_a_s0) m_lda = 1'b1;
      if (io_val_s0 && io_latch_b_s0) m_ldb = 1'b1;
`endif
      if (io_val_s0) begin
        if (io_latch_a_s0) ma = io_a_s0;
        if (io_latch_b_s0) mb = io_b_s0;
        p1 = 108'(ma) * 108'(mb);
      end
      v1 = io_val_s0;
    end
  end
  always @(negedge clock) begin
    chk("val_s3", 105'(io_val_s3), 105'(v3));
    chk("result_s3", io_result_s3, r3);
`ifdef MUL_ADD_PROTO_CHECK_EN
    chk("proto_err", 105'(io_proto_err), 105'(m_err));
`endif
  end
  function automatic logic [53:0] r54();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[53:0];
  endfunction
  function automatic logic [104:0] r105();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[104:0];
  endfunction
  task automatic drive(input logic v, input logic la, input logic [53:0] a, input logic lb,
                       input logic [53:0] b, input logic [104:0] c);
    io_val_s0 = v;
    io_latch_a_s0 = la;
    io_a_s0 = a;
    io_latch_b_s0 = lb;
    io_b_s0 = b;
    io_c_s2 = c;
    @(posedge clock);
    #1;
  endtask
  task automatic idle(input logic [104:0] c);
    drive(1'b0, 1'b0, r54(), 1'b0, r54(), c);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) idle(r105());
    reset = 1'b1;
    repeat (3) idle(r105());
  endtask
  logic [104:0] trunc_exp;
  logic [53:0] ones54;
  int vcnt;
  initial begin
    ones54 = '1;
    trunc_exp = {105{1'b1}} << 55;
    do_reset();
    chk("reset_val", 105'(io_val_s3), 105'd0);
    chk("reset_result", io_result_s3, 105'd0);
    drive(1'b1, 1'b1, 54'd3, 1'b1, 54'd5, r105());
    idle(r105());
    chk("basic_t2_val", 105'(io_val_s3), 105'd0);
    idle(105'd7);
    chk("basic_t3_val", 105'(io_val_s3), 105'd1);
    chk("basic_result", io_result_s3, 105'd22);
    idle(r105());
    chk("basic_t4_val", 105'(io_val_s3), 105'd0);
    drive(1'b1, 1'b1, 54'd1 << 53, 1'b1, 54'd2, r105());
    drive(1'b1, 1'b1, 54'd1, 1'b0, r54(), r105());
    idle(105'd0);
    chk("reuse_r1", io_result_s3, 105'd1 << 54);
    idle(105'd1);
    chk("reuse_r2", io_result_s3, 105'd3);
    drive(1'b1, 1'b1, ones54, 1'b1, ones54, r105());
    idle(r105());
    idle({105{1'b1}});
    chk("trunc_result", io_result_s3, trunc_exp);
    idle(r105());
    vcnt = 0;
    for (int i = 0; i < 11; i++) begin
      drive(i < 8, i < 8, r54(), i < 8, r54(), r105());
      chk("stream_slot", 105'(io_val_s3), 105'(i >= 2 && i < 10));
      if (io_val_s3) vcnt++;
    end
    chk("stream_count", 105'(vcnt), 105'd8);
    drive(1'b1, 1'b1, r54(), 1'b1, r54(), r105());
    reset = 1'b0;
    idle(r105());
    reset = 1'b1;
    idle(r105());
    idle(r105());
    chk("midrst_val", 105'(io_val_s3), 105'd0);
    chk("midrst_result", io_result_s3, 105'd0);
    repeat (3) idle(r105());
    drive(1'b1, 1'b1, 54'd6, 1'b1, 54'd7, r105());
    idle(r105());
    idle(105'd8);
    chk("post_rst_val", 105'(io_val_s3), 105'd1);
    chk("post_rst_result", io_result_s3, 105'd50);
    for (int i = 0; i < 300; i++) begin
      logic v;
      v = $urandom_range(0, 3) != 0;
      drive(v, $urandom_range(0, 1) == 1, r54(), $urandom_range(0, 1) == 1, r54(), r105());
    end
    repeat (4) idle(r105());
`ifdef MUL_ADD_PROTO_CHECK_EN
    do_reset();
    chk("perr_reset", 105'(io_proto_err), 105'd0);
    drive(1'b0, 1'b1, r54(), 1'b0, r54(), r105());
    chk("perr_latch_noval", 105'(io_proto_err), 105'd1);
    repeat (3) idle(r105());
    chk("perr_sticky", 105'(io_proto_err), 105'd1);
    do_reset();
    drive(1'b1, 1'b1, r54(), 1'b0, r54(), r105());
    chk("perr_unloaded_b", 105'(io_proto_err), 105'd1);
    repeat (3) idle(r105());
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_add_pipe54.md
Name: mul_add_pipe54

Overview:
- Responder end of the div/sqrt multiply-add request interface.
- The initiator issues operands at stage 0 and addend C at stage 2. This block returns (A*B + C) truncated to 105 bits at stage 3.
- Operand registers are kept, so an initiator can reuse A or B across back-to-back requests.
- Fixed-latency pipeline: it drops into the same slot the div/sqrt iteration engine drives.

Parameters:
- A_W, 54, width of operand A
- B_W, 54, width of operand B
- C_W, 105, width of addend C and result (product truncated to C_W)
- SPLIT, 27, low-slice width of B used for the two partial products (must satisfy 0 < SPLIT < B_W)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- io_val_s0  in  1  request valid at stage 0
- io_latch_a_s0  in  1  capture io_a_s0 into operand-A register (qualified by io_val_s0)
- io_a_s0  in  A_W  operand A
- io_latch_b_s0  in  1  capture io_b_s0 into operand-B register (qualified by io_val_s0)
- io_b_s0  in  B_W  operand B
- io_c_s2  in  C_W  addend, sampled in the cycle the request is at stage 2
- io_result_s3  out  C_W  registered result, valid in the cycle the request is at stage 3
- io_val_s3  out  1  result-valid strobe

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - all valid bits = 0
  - A/B/partial-product/result registers = 0
  - io_result_s3 = 0, io_val_s3 = 0
- Stage 0 (cycle t), when io_val_s0=1:
  - if io_latch_a_s0, regA <= io_a_s0
  - if io_latch_b_s0, regB <= io_b_s0
  - unlatched operand keeps its prior value, including across idle cycles
  - v1 <= io_val_s0
- Stage 1 (t+1), when v1=1:
  - pp_lo <= regA * regB[SPLIT-1:0], width A_W+SPLIT
  - pp_hi <= regA * regB[B_W-1:SPLIT], width A_W+B_W-SPLIT
  - v2 <= v1
- Stage 2 (t+2), when v2=1:
  - res <= (pp_lo + (pp_hi << SPLIT) + io_c_s2) mod 2^C_W
  - all intermediate sums are computed at full width, then truncated to C_W; no overflow flag
  - v3 <= v2
- Stage 3 (t+3):
  - io_result_s3 = res, io_val_s3 = v3
  - res holds its last value when v2=0
- Latency and throughput:
  - result is exactly 3 cycles after io_val_s0
  - one new request per cycle; no backpressure, no stall input
- io_latch_* with io_val_s0=0: ignored (no capture).
- io_c_s2 is don't-care when v2=0.
- Back-to-back requests: each stage advances independently. A latch at t+1 does not disturb the partial products computed for the request issued at t.
- Reset mid-operation: all in-flight requests are discarded. io_val_s3 is 0 from the reset edge until 3 cycles after the first post-reset io_val_s0.

Optional Feature:
- Macro MUL_ADD_PROTO_CHECK_EN.
- When defined, adds output io_proto_err (1 bit, reset 0). It is set sticky when either:
  - io_latch_a_s0 or io_latch_b_s0 is asserted while io_val_s0=0, or
  - io_val_s0=1 with a register never latched since reset (per-operand "loaded" bit).
- It is cleared only by reset.
- When undefined, the port and loaded bits are absent; datapath behaviour is identical.

Decomposition:
- Shared package mul_add_pkg:
  - width constants A_W/B_W/C_W/SPLIT defaults
  - localparam PP_LO_W = A_W+SPLIT, PP_HI_W = A_W+B_W-SPLIT
  - typedef for a stage-valid vector [3:1]
- One natural sub-module: mul_add_pp_stage. It is the stage-1 partial-product multiplier pair with its registers, reusable if SPLIT changes to three slices.
- Summation and control stay in the top.

Test Plan:
- Basic: A=3, B=5 (latch both), C=7 at t+2 -> io_result_s3=22, io_val_s3=1 exactly at t+3, 0 at t+2 and t+4.
- Operand reuse: request 1 A=2^53, B=2 (latch both), C=0. Request 2 next cycle with latch_a=1 only, A=1, C=1. Result 1 = 2^54, result 2 = 3 (regB=2 retained).
- Truncation: A=B=2^54-1, C=2^105-1 -> result = ((2^54-1)^2 + 2^105-1) mod 2^105 = 2^105-2^55 = 0x1FF...F80...0 (low 55 bits 0, bits 104:55 all 1); compare against the model.
- Pipelined stream: 8 consecutive valid requests with random A/B/C. Results appear on 8 consecutive cycles, each matching the reference model in order.
- Reset mid-flight: issue at t, drop reset at t+1 for one cycle -> io_val_s3=0 at t+3, io_result_s3=0. A request after release returns the correct value 3 cycles later.
- With MUL_ADD_PROTO_CHECK_EN:
  - latch_a=1, val=0 -> io_proto_err=1 next cycle and stays 1.
  - val=1 before any B latch -> io_proto_err=1.
